// File: rtl/my_if_tx.sv
// my_if transmitter: accepts host words via valid/ready and serializes them LSB-beat first
// onto the valid-only my_if bus with a programmable idle gap. Optional parity: MY_IF_TX_PARITY_EN.
module my_if_tx #(
    parameter int unsigned DW    = 8,
    parameter int unsigned BEATS = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW*BEATS-1:0]   in_data,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
`ifdef MY_IF_TX_PARITY_EN
    output logic                  out_par,
`endif
    output logic                  busy
);

    localparam int unsigned WW        = DW * BEATS;
    localparam logic [3:0]  BEAT_LAST = 4'(BEATS - 1);
    localparam logic [3:0]  GAP_LAST  = 4'((GAP == 0) ? 0 : GAP - 1);
    localparam logic        HAS_GAP   = 1'(GAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      beat_idx_q, beat_idx_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [WW-1:0]   shift_q, shift_d;
    logic [WW-1:0]   pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic            out_valid_d;
    logic [DW-1:0]   out_data_d;
    logic            busy_d;
    logic            accept;
    logic            load;
    logic            advance;

    // Pend is the only host-facing storage, so readiness is just "pend is free".
    assign in_ready = !rst && !pend_valid_q;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_idx_q   <= '0;
            gap_cnt_q    <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            out_valid    <= out_valid_d;
            out_data     <= out_data_d;
            busy         <= busy_d;
        end
    end

    // Next-state: decide whether this edge loads a new word, advances a beat, or idles.
    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        gap_cnt_d    = gap_cnt_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data;
        load         = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) load = 1'b1;
            end
            ST_SEND: begin
                if (HAS_GAP) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else if (beat_idx_q == BEAT_LAST) begin
                    if (pend_valid_q) load = 1'b1;
                    else              state_d = ST_IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (beat_idx_q == BEAT_LAST) begin
                        if (pend_valid_q) load = 1'b1;
                        else              state_d = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d     = ST_SEND;
            beat_idx_d  = '0;
            out_valid_d = 1'b1;
            out_data_d  = pend_q[DW-1:0];
            shift_d     = pend_q >> DW;
        end
        if (advance) begin
            state_d     = ST_SEND;
            beat_idx_d  = beat_idx_q + 4'd1;
            out_valid_d = 1'b1;
            out_data_d  = shift_q[DW-1:0];
            shift_d     = shift_q >> DW;
        end

        if (accept) pend_d = in_data;
        pend_valid_d = (pend_valid_q && !load) || accept;
        busy_d       = (state_d != ST_IDLE) || pend_valid_d;
    end

`ifdef MY_IF_TX_PARITY_EN
    // Parity travels with the beat it covers and is forced low outside valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_par <= 1'b0;
        else     out_par <= out_valid_d & (^out_data_d);
    end
`endif

endmodule

// File: tb/tb_my_if_tx.sv
// Bench for my_if_tx: three configurations (4 beats/no gap, 4 beats/gap 2, 1 beat/no gap)
// with per-instance scoreboards of expected beats checked whenever out_valid is seen.
module tb_my_if_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance 0: DW=8 BEATS=4 GAP=0
    logic        iv0 = 1'b0, ir0, ov0, bz0;
    logic [31:0] id0 = '0;
    logic [7:0]  od0;
    // instance 1: DW=8 BEATS=4 GAP=2
    logic        iv1 = 1'b0, ir1, ov1, bz1;
    logic [31:0] id1 = '0;
    logic [7:0]  od1;
    // instance 2: DW=8 BEATS=1 GAP=0
    logic        iv2 = 1'b0, ir2, ov2, bz2;
    logic [7:0]  id2 = '0;
    logic [7:0]  od2;
`ifdef MY_IF_TX_PARITY_EN
    logic        op0, op1, op2;
`endif

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    my_if_tx #(.DW(8), .BEATS(4), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_data(od0),
`ifdef MY_IF_TX_PARITY_EN
        .out_par(op0),
`endif
        .busy(bz0));

    my_if_tx #(.DW(8), .BEATS(4), .GAP(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_data(od1),
`ifdef MY_IF_TX_PARITY_EN
        .out_par(op1),
`endif
        .busy(bz1));

    my_if_tx #(.DW(8), .BEATS(1), .GAP(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_data(od2),
`ifdef MY_IF_TX_PARITY_EN
        .out_par(op2),
`endif
        .busy(bz2));

    // Scoreboard monitors: every valid beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && ov0) begin
            total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL beat0_unexpected got=%h required=none", od0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (od0 !== e) begin bad++; $display("FAIL beat0 got=%h required=%h", od0, e); end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && ov1) begin
            total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL beat1_unexpected got=%h required=none", od1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (od1 !== e) begin bad++; $display("FAIL beat1 got=%h required=%h", od1, e); end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && ov2) begin
            total++;
            if (q2.size() == 0) begin
                bad++; $display("FAIL beat2_unexpected got=%h required=none", od2);
            end else begin
                logic [7:0] e;
                e = q2.pop_front();
                if (od2 !== e) begin bad++; $display("FAIL beat2 got=%h required=%h", od2, e); end
            end
        end
    end

    // Called at a negedge; leaves in_valid high and returns at the negedge after the transfer edge.
    task automatic put0(input logic [31:0] w);
        int n = 0;
        iv0 = 1'b1; id0 = w;
        while (ir0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL put0_timeout got=ready_low required=ready_high"); end
        for (int b = 0; b < 4; b++) q0.push_back(w[8*b +: 8]);
        @(negedge clk);
    endtask

    task automatic put1(input logic [31:0] w);
        int n = 0;
        iv1 = 1'b1; id1 = w;
        while (ir1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL put1_timeout got=ready_low required=ready_high"); end
        for (int b = 0; b < 4; b++) q1.push_back(w[8*b +: 8]);
        @(negedge clk);
    endtask

    task automatic put2(input logic [7:0] w);
        int n = 0;
        iv2 = 1'b1; id2 = w;
        while (ir2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL put2_timeout got=ready_low required=ready_high"); end
        q2.push_back(w);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ov0, od0, bz0, ir0} !== 11'b0) begin
            bad++; $display("FAIL reset_u0 got=%b required=0", {ov0, od0, bz0, ir0});
        end
        total++;
        if ({ov1, bz1, ir1, ov2, bz2, ir2} !== 6'b0) begin
            bad++; $display("FAIL reset_u1u2 got=%b required=0", {ov1, bz1, ir1, ov2, bz2, ir2});
        end
        rst = 1'b0;
        #1;
        total++;
        if (ir0 !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b required=1", ir0); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        put0(32'hDDCCBBAA);
        iv0 = 1'b0;
        total++;
        if (ov0 !== 1'b0 || bz0 !== 1'b1) begin
            bad++; $display("FAIL basic_latency got=v%b/b%b required=v0/b1", ov0, bz0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (ov0 !== 1'b1) begin bad++; $display("FAIL basic_valid%0d got=%b required=1", i, ov0); end
        end
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || bz0 !== 1'b0) begin
            bad++; $display("FAIL basic_end got=v%b/b%b required=v0/b0", ov0, bz0);
        end
        total++;
        if (od0 !== 8'hDD) begin bad++; $display("FAIL basic_hold got=%h required=dd", od0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        put0(32'h04030201);
        total++;
        if (ir0 !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b required=0", ir0); end
        put0(32'h08070605);
        iv0 = 1'b0;
        total++;
        if (ir0 !== 1'b0) begin bad++; $display("FAIL b2b_ready_full2 got=%b required=0", ir0); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (ov0 !== 1'b1) begin bad++; $display("FAIL b2b_bubble%0d got=%b required=1", i, ov0); end
        end
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || bz0 !== 1'b0) begin
            bad++; $display("FAIL b2b_end got=v%b/b%b required=v0/b0", ov0, bz0);
        end
    endtask

    task automatic test_gap();
        @(negedge clk);
        put1(32'h44332211);
        iv1 = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            logic ev, eb;
            @(negedge clk);
            ev = ((i - 1) % 3 == 0) && (i <= 10);
            eb = (i <= 12);
            total++;
            if (ov1 !== ev || bz1 !== eb) begin
                bad++; $display("FAIL gap_cycle%0d got=v%b/b%b required=v%b/b%b", i, ov1, bz1, ev, eb);
            end
        end
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        put2(8'h5A);
        put2(8'hA5);
        put2(8'hFF);
        iv2 = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (q2.size() != 0 || ov2 !== 1'b0 || bz2 !== 1'b0) begin
            bad++; $display("FAIL single_drain got=left%0d/v%b required=left0/v0", q2.size(), ov2);
        end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        put0(32'hDDCCBBAA);
        put0(32'h11223344);
        iv0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ov0 !== 1'b0 || ir0 !== 1'b0 || bz0 !== 1'b0) begin
            bad++; $display("FAIL midreset_async got=v%b/r%b/b%b required=v0/r0/b0", ov0, ir0, bz0);
        end
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (ir0 !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b required=1", ir0); end
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ov0 !== 1'b0 || bz0 !== 1'b0) seen++;
            end
            total++;
            if (seen != 0) begin bad++; $display("FAIL midreset_quiet got=%0d required=0", seen); end
        end
    endtask

`ifdef MY_IF_TX_PARITY_EN
    task automatic test_parity();
        logic [4:0] ep;
        ep = 5'b00010;
        @(negedge clk);
        put0(32'h00000703);
        iv0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (op0 !== ep[i]) begin bad++; $display("FAIL parity%0d got=%b required=%b", i, op0, ep[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_single_beat();
`ifdef MY_IF_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_word();
        total++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d required=0", q0.size() + q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
